// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage with a variable-latency instruction bus and a
// DEPTH-entry prefetch queue. It owns the fetch PC, issues requests while
// the queue plus in-flight requests still have room, and tags each request
// with its PC in an in-order tag FIFO. Returned words are pushed into the
// prefetch queue and presented to decode through a valid/ready handshake.
// Illegal fetch PCs produce a single exception entry, after which fetch
// halts until a redirect. A redirect flushes the queue and marks every
// in-flight request as stale so that its response is discarded.
//
// Parameters
//   XLEN       address / PC width
//   DEPTH      prefetch queue entries (power of two, >= 2)
//   RESET_PC   fetch PC after reset
//   TEXT_BASE  lowest legal fetch address
//   TEXT_END   highest legal fetch address (inclusive)
//
// Ports
//   iCLK         clock, rising edge
//   iRST_N       asynchronous active-low reset
//   oIReq        instruction bus request valid
//   oIAddr       instruction bus request address (fetch PC)
//   iIGnt        request accepted this cycle
//   iIRValid     response valid (responses return in issue order)
//   iIRData      response instruction word
//   iRedirect    flush and restart fetch at iRedirectPC
//   iRedirectPC  new fetch PC
//   oValid       queue head valid toward decode
//   oInstr       head instruction (zero for exception entries)
//   oPC          address of head instruction
//   oExc         head entry is a fetch exception
//   oCause       exception cause (0 misaligned, 1 outside .text)
//   iReady       decode accepts head
//   oCount       occupied queue entries
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                XLEN      = 32,
    parameter int                DEPTH     = 4,
    parameter logic [XLEN-1:0]   RESET_PC  = 32'h0040_0000,
    parameter logic [XLEN-1:0]   TEXT_BASE = 32'h0040_0000,
    parameter logic [XLEN-1:0]   TEXT_END  = 32'h0040_FFFC
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    output logic                       oIReq,
    output logic [XLEN-1:0]            oIAddr,
    input  logic                       iIGnt,
    input  logic                       iIRValid,
    input  logic [31:0]                iIRData,
    input  logic                       iRedirect,
    input  logic [XLEN-1:0]            iRedirectPC,
    output logic                       oValid,
    output logic [31:0]                oInstr,
    output logic [XLEN-1:0]            oPC,
    output logic                       oExc,
    output logic [XLEN-1:0]            oCause,
    input  logic                       iReady,
    output logic [$clog2(DEPTH):0]     oCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } modeT;

    // Architectural fetch state
    logic [XLEN-1:0] fpc;
    modeT            mode;
    logic            armed;

    // Prefetch queue
    logic [31:0]      qInstr [DEPTH];
    logic [XLEN-1:0]  qPc    [DEPTH];
    logic [DEPTH-1:0] qExc;
    logic [DEPTH-1:0] qCause;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    count;

    // In-order PC tags for requests still on the bus
    logic [XLEN-1:0]  tagPc [DEPTH];
    logic [PW-1:0]    tagRd;
    logic [PW-1:0]    tagWr;

    // Requests in flight, and how many of them are stale
    logic [CW-1:0]    outCnt;
    logic [CW-1:0]    dropCnt;

    // Per-cycle events
    logic misaligned;
    logic outOfText;
    logic fpcLegal;
    logic haveCredit;
    logic issue;
    logic respTracked;
    logic respDrop;
    logic respWrite;
    logic excPush;
    logic push;
    logic pop;

    // Legality of the current fetch PC. A misaligned PC takes priority over
    // the range check when choosing the cause. Wrap-around of fpc past the
    // top of the address space lands below TEXT_BASE and is caught here.
    always_comb begin
        misaligned = (fpc[1:0] != 2'b00);
        outOfText  = (fpc < TEXT_BASE) || (fpc > TEXT_END);
        fpcLegal   = !misaligned && !outOfText;
    end

    // Request and queue event decode. Credit counts queued entries plus
    // in-flight requests, so every response is guaranteed a free slot.
    // The request depends on registers only, never on the grant input.
    // 'armed' keeps the request low while reset is asserted and for the
    // first edge after release.
    always_comb begin
        haveCredit  = (({1'b0, count} + {1'b0, outCnt}) < DEPTH_EXT);
        oIReq       = armed && (mode == RUN) && fpcLegal && haveCredit;
        oIAddr      = fpc;
        issue       = oIReq && iIGnt;
        respTracked = iIRValid && (outCnt != '0);
        respDrop    = respTracked && (dropCnt != '0);
        respWrite   = respTracked && (dropCnt == '0);
        excPush     = armed && (mode == RUN) && !fpcLegal &&
                      (outCnt == '0) && (count != FULL);
        push        = respWrite || excPush;
        pop         = oValid && iReady;
    end

    // Head-of-queue presentation to decode. Payload fields are forced to
    // zero whenever they are not meaningful so decode never sees stale data.
    always_comb begin
        oValid = (count != '0);
        oCount = count;
        oExc   = oValid && qExc[rdPtr];
        oPC    = oValid ? qPc[rdPtr] : '0;
        oInstr = (oValid && !qExc[rdPtr]) ? qInstr[rdPtr] : 32'h0;
        oCause = oExc ? {{(XLEN-1){1'b0}}, qCause[rdPtr]} : '0;
    end

    // Control state. The tag FIFO and the in-flight counter follow the bus
    // regardless of redirects, because stale responses still arrive and must
    // consume their tags. On a redirect every request that will still be in
    // flight after this edge becomes stale, so the drop counter is loaded
    // with the updated in-flight count rather than accumulated, which keeps
    // it from ever exceeding outCnt. Any push or pop in a redirect cycle is
    // discarded along with the queue contents.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fpc     <= RESET_PC;
            mode    <= RUN;
            armed   <= 1'b0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            tagRd   <= '0;
            tagWr   <= '0;
            outCnt  <= '0;
            dropCnt <= '0;
        end else begin
            armed <= 1'b1;
            if (issue) begin
                tagWr <= tagWr + 1'b1;
            end
            if (respTracked) begin
                tagRd <= tagRd + 1'b1;
            end
            outCnt <= outCnt + CW'(issue) - CW'(respTracked);

            if (iRedirect) begin
                fpc     <= iRedirectPC;
                mode    <= RUN;
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
                dropCnt <= outCnt + CW'(issue) - CW'(respTracked);
            end else begin
                if (issue) begin
                    fpc <= fpc + XLEN'(4);
                end
                if (respDrop) begin
                    dropCnt <= dropCnt - 1'b1;
                end
                if (excPush) begin
                    mode <= HALT;
                end
                if (push) begin
                    wrPtr <= wrPtr + 1'b1;
                end
                if (pop) begin
                    rdPtr <= rdPtr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays. These need no reset: nothing is visible unless the
    // reset-cleared occupancy count says the slot is valid. An exception
    // entry records the offending PC and stores the cause as a single bit
    // (1 = outside .text, 0 = misaligned).
    always_ff @(posedge iCLK) begin
        if (issue) begin
            tagPc[tagWr] <= fpc;
        end
        if (push && !iRedirect) begin
            if (respWrite) begin
                qInstr[wrPtr] <= iIRData;
                qPc[wrPtr]    <= tagPc[tagRd];
                qExc[wrPtr]   <= 1'b0;
                qCause[wrPtr] <= 1'b0;
            end else begin
                qInstr[wrPtr] <= 32'h0;
                qPc[wrPtr]    <= fpc;
                qExc[wrPtr]   <= 1'b1;
                qCause[wrPtr] <= !misaligned;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with the default parameters. A small
// in-order memory model with programmable latency answers requests; each
// scenario task drives its own stimulus and checks against hand-derived
// values.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        iCLK;
    logic        iRST_N;
    logic        oIReq;
    logic [31:0] oIAddr;
    logic        iIGnt;
    logic        iIRValid;
    logic [31:0] iIRData;
    logic        iRedirect;
    logic [31:0] iRedirectPC;
    logic        oValid;
    logic [31:0] oInstr;
    logic [31:0] oPC;
    logic        oExc;
    logic [31:0] oCause;
    logic        iReady;
    logic [2:0]  oCount;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReqT;

    memReqT      memQ[$];
    int          cyc;
    int          lat;
    logic        lastIssued;
    logic [31:0] lastAddr;

    fetch_unit dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .oIReq       (oIReq),
        .oIAddr      (oIAddr),
        .iIGnt       (iIGnt),
        .iIRValid    (iIRValid),
        .iIRData     (iIRData),
        .iRedirect   (iRedirect),
        .iRedirectPC (iRedirectPC),
        .oValid      (oValid),
        .oInstr      (oInstr),
        .oPC         (oPC),
        .oExc        (oExc),
        .oCause      (oCause),
        .iReady      (iReady),
        .oCount      (oCount)
    );

    // Free-running 10-unit clock
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Memory contents: a recognisable word derived from the address
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[17:2], 16'h0013};
    endfunction

    // One clock cycle: present the due response (if any), record whether a
    // request is issued, advance past the edge and update the memory model.
    task automatic step();
        logic sendResp;
        sendResp = 1'b0;
        iIRData  = 32'h0;
        if (memQ.size() > 0) begin
            if (memQ[0].due <= cyc) begin
                sendResp = 1'b1;
                iIRData  = instrOf(memQ[0].addr);
            end
        end
        iIRValid   = sendResp;
        lastIssued = oIReq & iIGnt;
        lastAddr   = oIAddr;
        @(posedge iCLK);
        #1;
        if (sendResp) begin
            void'(memQ.pop_front());
        end
        if (lastIssued) begin
            memQ.push_back('{addr: lastAddr, due: cyc + lat});
        end
        cyc++;
        iIRValid = 1'b0;
    endtask

    // Reset the DUT and memory, release away from the edge, then take the
    // first clock edge after release with the grant held low.
    task automatic doReset();
        iRST_N      = 1'b0;
        iIGnt       = 1'b0;
        iReady      = 1'b0;
        iRedirect   = 1'b0;
        iRedirectPC = 32'h0;
        iIRValid    = 1'b0;
        iIRData     = 32'h0;
        memQ.delete();
        repeat (2) @(posedge iCLK);
        #3;
        iRST_N = 1'b1;
        step();
    endtask

    task automatic test_reset();
        iRST_N      = 1'b0;
        iIGnt       = 1'b1;
        iReady      = 1'b1;
        iRedirect   = 1'b0;
        iRedirectPC = 32'h0;
        iIRValid    = 1'b0;
        iIRData     = 32'h0;
        lat         = 1;
        repeat (2) @(posedge iCLK);
        #1;
        vectors++; if (oIReq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ireq got=%0h exp=0", oIReq); end
        vectors++; if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got=%0h exp=0", oValid); end
        vectors++; if (oExc !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_exc got=%0h exp=0", oExc); end
        vectors++; if (oCount !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count got=%0d exp=0", oCount); end
        vectors++; if (oInstr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr got=%h exp=0", oInstr); end
        vectors++; if (oPC !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc got=%h exp=0", oPC); end
        vectors++; if (oCause !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_cause got=%h exp=0", oCause); end
        vectors++; if (oIAddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL reset_iaddr got=%h exp=%h", oIAddr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] expIss;
        logic [31:0] expPc;
        int          pops;
        doReset();
        lat    = 1;
        iIGnt  = 1'b1;
        iReady = 1'b1;
        expIss = RESET_PC;
        expPc  = RESET_PC;
        pops   = 0;
        for (int i = 0; i < 14; i++) begin
            if (oIReq) begin
                vectors++; if (oIAddr !== expIss) begin miscompares++; $display("[TB] FAIL stream_iaddr got=%h exp=%h", oIAddr, expIss); end
                expIss = expIss + 32'd4;
            end
            if (oValid) begin
                vectors++; if (oPC !== expPc) begin miscompares++; $display("[TB] FAIL stream_pc got=%h exp=%h", oPC, expPc); end
                vectors++; if (oInstr !== instrOf(expPc)) begin miscompares++; $display("[TB] FAIL stream_instr got=%h exp=%h", oInstr, instrOf(expPc)); end
                vectors++; if (oExc !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_exc got=%0h exp=0", oExc); end
                expPc = expPc + 32'd4;
                pops++;
            end
            step();
        end
        vectors++; if (pops !== 12) begin miscompares++; $display("[TB] FAIL stream_throughput got=%0d exp=12", pops); end
    endtask

    task automatic test_full();
        int issues;
        doReset();
        lat    = 1;
        iIGnt  = 1'b1;
        iReady = 1'b0;
        issues = 0;
        repeat (10) begin
            step();
            if (lastIssued) issues++;
        end
        vectors++; if (issues !== 4) begin miscompares++; $display("[TB] FAIL full_issues got=%0d exp=4", issues); end
        vectors++; if (oCount !== 3'd4) begin miscompares++; $display("[TB] FAIL full_count got=%0d exp=4", oCount); end
        vectors++; if (oIReq !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ireq got=%0h exp=0", oIReq); end
        vectors++; if (oPC !== RESET_PC) begin miscompares++; $display("[TB] FAIL full_head got=%h exp=%h", oPC, RESET_PC); end
        iReady = 1'b1;
        step();
        iReady = 1'b0;
        vectors++; if (oCount !== 3'd3) begin miscompares++; $display("[TB] FAIL full_after_pop got=%0d exp=3", oCount); end
        vectors++; if (oPC !== RESET_PC + 32'd4) begin miscompares++; $display("[TB] FAIL full_next_head got=%h exp=%h", oPC, RESET_PC + 32'd4); end
        issues = 0;
        repeat (4) begin
            step();
            if (lastIssued) issues++;
        end
        vectors++; if (issues !== 1) begin miscompares++; $display("[TB] FAIL full_refill got=%0d exp=1", issues); end
        vectors++; if (oCount !== 3'd4) begin miscompares++; $display("[TB] FAIL full_refill_count got=%0d exp=4", oCount); end
    endtask

    task automatic test_redirect_drop();
        logic found;
        doReset();
        lat    = 3;
        iIGnt  = 1'b1;
        iReady = 1'b0;
        step();
        step();
        vectors++; if (memQ.size() !== 2) begin miscompares++; $display("[TB] FAIL redir_outstanding got=%0d exp=2", memQ.size()); end
        iIGnt       = 1'b0;
        iRedirect   = 1'b1;
        iRedirectPC = 32'h0040_0100;
        step();
        iRedirect = 1'b0;
        vectors++; if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_valid got=%0h exp=0", oValid); end
        vectors++; if (oIAddr !== 32'h0040_0100) begin miscompares++; $display("[TB] FAIL redir_iaddr got=%h exp=00400100", oIAddr); end
        vectors++; if (oIReq !== 1'b1) begin miscompares++; $display("[TB] FAIL redir_ireq got=%0h exp=1", oIReq); end
        iIGnt  = 1'b1;
        iReady = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (oValid) begin
                found = 1'b1;
                vectors++; if (oPC !== 32'h0040_0100) begin miscompares++; $display("[TB] FAIL redir_first_pc got=%h exp=00400100", oPC); end
                vectors++; if (oInstr !== instrOf(32'h0040_0100)) begin miscompares++; $display("[TB] FAIL redir_first_instr got=%h exp=%h", oInstr, instrOf(32'h0040_0100)); end
            end else begin
                step();
            end
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("[TB] FAIL redir_timeout got=no entry exp=entry within 20 cycles");
        end
    endtask

    task automatic test_misaligned();
        doReset();
        lat         = 1;
        iIGnt       = 1'b0;
        iReady      = 1'b0;
        iRedirect   = 1'b1;
        iRedirectPC = 32'h0040_0102;
        step();
        iRedirect = 1'b0;
        iIGnt     = 1'b1;
        vectors++; if (oIReq !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_ireq got=%0h exp=0", oIReq); end
        step();
        vectors++; if (oValid !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_valid got=%0h exp=1", oValid); end
        vectors++; if (oExc !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_exc got=%0h exp=1", oExc); end
        vectors++; if (oCause !== 32'd0) begin miscompares++; $display("[TB] FAIL mis_cause got=%h exp=0", oCause); end
        vectors++; if (oPC !== 32'h0040_0102) begin miscompares++; $display("[TB] FAIL mis_pc got=%h exp=00400102", oPC); end
        vectors++; if (oInstr !== 32'h0) begin miscompares++; $display("[TB] FAIL mis_instr got=%h exp=0", oInstr); end
        vectors++; if (oCount !== 3'd1) begin miscompares++; $display("[TB] FAIL mis_count got=%0d exp=1", oCount); end
        iReady = 1'b1;
        repeat (4) step();
        vectors++; if (oCount !== 3'd0) begin miscompares++; $display("[TB] FAIL mis_halt_count got=%0d exp=0", oCount); end
        vectors++; if (oIReq !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_halt_ireq got=%0h exp=0", oIReq); end
        iRedirect   = 1'b1;
        iRedirectPC = 32'h0040_0200;
        step();
        iRedirect = 1'b0;
        vectors++; if (oIReq !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_resume_ireq got=%0h exp=1", oIReq); end
        vectors++; if (oIAddr !== 32'h0040_0200) begin miscompares++; $display("[TB] FAIL mis_resume_iaddr got=%h exp=00400200", oIAddr); end
    endtask

    task automatic test_text_end();
        logic found;
        doReset();
        lat         = 1;
        iIGnt       = 1'b0;
        iReady      = 1'b0;
        iRedirect   = 1'b1;
        iRedirectPC = 32'h0040_FFF8;
        step();
        iRedirect = 1'b0;
        iIGnt     = 1'b1;
        repeat (8) step();
        vectors++; if (oCount !== 3'd3) begin miscompares++; $display("[TB] FAIL end_count got=%0d exp=3", oCount); end
        vectors++; if (oPC !== 32'h0040_FFF8) begin miscompares++; $display("[TB] FAIL end_head0 got=%h exp=0040fff8", oPC); end
        vectors++; if (oExc !== 1'b0) begin miscompares++; $display("[TB] FAIL end_head0_exc got=%0h exp=0", oExc); end
        iReady = 1'b1;
        step();
        vectors++; if (oPC !== 32'h0040_FFFC) begin miscompares++; $display("[TB] FAIL end_head1 got=%h exp=0040fffc", oPC); end
        vectors++; if (oInstr !== instrOf(32'h0040_FFFC)) begin miscompares++; $display("[TB] FAIL end_head1_instr got=%h exp=%h", oInstr, instrOf(32'h0040_FFFC)); end
        step();
        iReady = 1'b0;
        vectors++; if (oExc !== 1'b1) begin miscompares++; $display("[TB] FAIL end_exc got=%0h exp=1", oExc); end
        vectors++; if (oCause !== 32'd1) begin miscompares++; $display("[TB] FAIL end_cause got=%h exp=1", oCause); end
        vectors++; if (oPC !== 32'h0041_0000) begin miscompares++; $display("[TB] FAIL end_exc_pc got=%h exp=00410000", oPC); end
        vectors++; if (oInstr !== 32'h0) begin miscompares++; $display("[TB] FAIL end_exc_instr got=%h exp=0", oInstr); end
        iReady      = 1'b1;
        iRedirect   = 1'b1;
        iRedirectPC = RESET_PC;
        step();
        iRedirect = 1'b0;
        vectors++; if (oCount !== 3'd0) begin miscompares++; $display("[TB] FAIL end_flush_count got=%0d exp=0", oCount); end
        vectors++; if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL end_flush_valid got=%0h exp=0", oValid); end
        vectors++; if (oIReq !== 1'b1) begin miscompares++; $display("[TB] FAIL end_restart_ireq got=%0h exp=1", oIReq); end
        vectors++; if (oIAddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL end_restart_iaddr got=%h exp=%h", oIAddr, RESET_PC); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (oValid) begin
                found = 1'b1;
                vectors++; if (oPC !== RESET_PC) begin miscompares++; $display("[TB] FAIL end_restart_pc got=%h exp=%h", oPC, RESET_PC); end
            end else begin
                step();
            end
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("[TB] FAIL end_restart_timeout got=no entry exp=entry within 10 cycles");
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        doReset();
        lat    = 1;
        iIGnt  = 1'b1;
        iReady = 1'b1;
        repeat (5) step();
        vectors++; if (oValid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy got=%0h exp=1", oValid); end
        iRST_N   = 1'b0;
        iIRValid = 1'b0;
        memQ.delete();
        #1;
        vectors++; if (oIReq !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ireq got=%0h exp=0", oIReq); end
        vectors++; if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid got=%0h exp=0", oValid); end
        vectors++; if (oCount !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_count got=%0d exp=0", oCount); end
        vectors++; if (oPC !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_pc got=%h exp=0", oPC); end
        vectors++; if (oInstr !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_instr got=%h exp=0", oInstr); end
        vectors++; if (oIAddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL mid_iaddr got=%h exp=%h", oIAddr, RESET_PC); end
        repeat (2) @(posedge iCLK);
        #3;
        iRST_N = 1'b1;
        step();
        vectors++; if (oIReq !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_restart_ireq got=%0h exp=1", oIReq); end
        vectors++; if (oIAddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL mid_restart_iaddr got=%h exp=%h", oIAddr, RESET_PC); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (oValid) begin
                found = 1'b1;
                vectors++; if (oPC !== RESET_PC) begin miscompares++; $display("[TB] FAIL mid_restart_pc got=%h exp=%h", oPC, RESET_PC); end
            end else begin
                step();
            end
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("[TB] FAIL mid_restart_timeout got=no entry exp=entry within 10 cycles");
        end
    endtask

    // Scenario sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        lat         = 1;
        iRST_N      = 1'b0;
        iIGnt       = 1'b0;
        iReady      = 1'b0;
        iRedirect   = 1'b0;
        iRedirectPC = 32'h0;
        iIRValid    = 1'b0;
        iIRData     = 32'h0;
        $display("[TB] fetch_unit directed tests start");
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_misaligned();
        test_text_end();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound in case a scenario stalls unexpectedly
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
